// File: rtl/ticket_counter_arbiter.sv
// Shared wrap-around ticket counter behind a round-robin arbiter, with the issued
// ticket and requester ID carried through a STAGES-deep valid/ready pipeline.
module ticket_counter_arbiter #(
    parameter int N      = 4,
    parameter int REQS   = 4,
    parameter int STAGES = 2,
    localparam int IDW   = $clog2(REQS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic [REQS-1:0] req,
    output logic [REQS-1:0] grant,
    output logic            out_valid,
    output logic [N-1:0]    out_ticket,
    output logic [IDW-1:0]  out_id,
    input  logic            out_ready,
    output logic            busy
);

    logic [N-1:0]               cnt_q, cnt_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [STAGES-1:0]          vld_q, vld_d;
    logic [STAGES-1:0][N-1:0]   tkt_q, tkt_d;
    logic [STAGES-1:0][IDW-1:0] id_q, id_d;

    logic                       advance_s;
    logic                       accept_s;
    logic [IDW-1:0]             gidx_s;
    logic [IDW-1:0]             idx_s;
    logic [IDW-1:0]             ptr_inc_s;
    logic [REQS-1:0]            grant_s;
    int                         pos_s;

    // A full output slot that is not being taken freezes the whole block.
    assign advance_s = ~(vld_q[STAGES-1] & ~out_ready);

    // Round-robin search: walking downward means the candidate closest to ptr wins last.
    always_comb begin
        gidx_s = {IDW{1'b0}};
        idx_s  = {IDW{1'b0}};
        pos_s  = 0;
        for (int k = REQS - 1; k >= 0; k--) begin
            pos_s  = int'(ptr_q) + k;
            pos_s  = (pos_s >= REQS) ? (pos_s - REQS) : pos_s;
            idx_s  = IDW'(pos_s);
            gidx_s = req[idx_s] ? idx_s : gidx_s;
        end
    end

    // Grant decode, suppressed during reset, clear, stall or when nobody asks.
    always_comb begin
        grant_s = {REQS{1'b0}};
        if (!reset && !clr && advance_s && (|req)) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = {REQS{1'b0}};
        end
    end

    assign accept_s  = |grant_s;
    assign ptr_inc_s = (gidx_s == IDW'(REQS - 1)) ? {IDW{1'b0}} : (gidx_s + IDW'(1));

    // Next state for counter, pointer and pipeline stages.
    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        vld_d = vld_q;
        tkt_d = tkt_q;
        id_d  = id_q;

        if (clr) begin
            cnt_d = {N{1'b0}};
            ptr_d = {IDW{1'b0}};
        end else if (accept_s) begin
            cnt_d = cnt_q + N'(1);
            ptr_d = ptr_inc_s;
        end else begin
            cnt_d = cnt_q;
            ptr_d = ptr_q;
        end

        if (advance_s) begin
            vld_d[0] = accept_s;
            tkt_d[0] = accept_s ? cnt_q : tkt_q[0];
            id_d[0]  = accept_s ? gidx_s : id_q[0];
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                tkt_d[i] = tkt_q[i-1];
                id_d[i]  = id_q[i-1];
            end
        end else begin
            vld_d = vld_q;
            tkt_d = tkt_q;
            id_d  = id_q;
        end
    end

    // State registers; reset discards anything still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {N{1'b0}};
            ptr_q <= {IDW{1'b0}};
            vld_q <= {STAGES{1'b0}};
            tkt_q <= {(STAGES*N){1'b0}};
            id_q  <= {(STAGES*IDW){1'b0}};
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            tkt_q <= tkt_d;
            id_q  <= id_d;
        end
    end

    assign grant      = grant_s;
    assign out_valid  = vld_q[STAGES-1];
    assign out_ticket = tkt_q[STAGES-1];
    assign out_id     = id_q[STAGES-1];
    assign busy       = |vld_q;

    ticket_counter_arbiter_chk #(
        .N    (N),
        .REQS (REQS),
        .IDW  (IDW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .grant      (grant_s),
        .out_valid  (vld_q[STAGES-1]),
        .out_ready  (out_ready),
        .out_ticket (tkt_q[STAGES-1]),
        .out_id     (id_q[STAGES-1])
    );

endmodule

// Protocol properties of the arbiter output and grant, kept apart from the datapath.
module ticket_counter_arbiter_chk #(
    parameter int N    = 4,
    parameter int REQS = 4,
    parameter int IDW  = 2
) (
    input logic            clk,
    input logic            reset,
    input logic [REQS-1:0] grant,
    input logic            out_valid,
    input logic            out_ready,
    input logic [N-1:0]    out_ticket,
    input logic [IDW-1:0]  out_id
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

    a_stall_no_grant: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |-> (grant == {REQS{1'b0}}));

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_ticket) && $stable(out_id)));

endmodule

// File: tb/tb_ticket_counter_arbiter.sv
// Directed bench for ticket_counter_arbiter: stimulus pushes expected tickets into a
// scoreboard queue, an independent monitor pops and compares on every output transfer.
module tb_ticket_counter_arbiter;

    localparam int N      = 4;
    localparam int REQS   = 4;
    localparam int STAGES = 2;
    localparam int IDW    = 2;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            clr       = 1'b0;
    logic [REQS-1:0] req       = 4'b0000;
    logic            out_ready = 1'b1;
    logic [REQS-1:0] grant;
    logic            out_valid;
    logic [N-1:0]    out_ticket;
    logic [IDW-1:0]  out_id;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N+IDW-1:0] exp_q[$];
    logic [N+IDW-1:0] mon_e;

    ticket_counter_arbiter #(
        .N      (N),
        .REQS   (REQS),
        .STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .req        (req),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_ticket (out_ticket),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One cycle: drive inputs, check the combinational grant, record the expected ticket.
    task automatic step(input logic [REQS-1:0] r, input logic rdy, input logic c,
                        input logic [REQS-1:0] eg, input logic [N-1:0] et,
                        input logic [IDW-1:0] ei);
        req       = r;
        out_ready = rdy;
        clr       = c;
        #1;
        check("grant", int'(grant), int'(eg));
        if (eg != 4'b0000) exp_q.push_back({et, ei});
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'd0, 2'd0);
    endtask

    // Scoreboard monitor, sampling mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: ticket=%0d id=%0d with empty scoreboard", out_ticket, out_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_ticket", int'(out_ticket), int'(mon_e[N+IDW-1:IDW]));
                check("out_id", int'(out_id), int'(mon_e[IDW-1:0]));
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_ticket", int'(out_ticket), 0);
        check("rst_id", int'(out_id), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester 2: first grant right after reset release, outputs from cycle 2
        for (int i = 0; i < 6; i++) begin
            check("single_valid", int'(out_valid), (i >= 2) ? 1 : 0);
            step(4'b0100, 1'b1, 1'b0, 4'b0100, N'(i), 2'd2);
        end
        idle(2);

        // Clear then round-robin over all four requesters
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 4'd0, 2'd0);
        for (int i = 0; i < 8; i++)
            step(4'b1111, 1'b1, 1'b0, REQS'(4'b0001 << (i % 4)), N'(i), IDW'(i % 4));
        idle(2);

        // Backpressure: tickets 8,9 issue, then a 3-cycle stall holding ticket 8
        step(4'b0001, 1'b1, 1'b0, 4'b0001, 4'd8, 2'd0);
        step(4'b0001, 1'b1, 1'b0, 4'b0001, 4'd9, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_ticket", int'(out_ticket), 8);
            check("stall_id", int'(out_id), 0);
            check("stall_busy", int'(busy), 1);
            step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'd0, 2'd0);
        end
        check("stall_release_ticket", int'(out_ticket), 8);
        for (int i = 0; i < 4; i++)
            step(4'b0001, 1'b1, 1'b0, 4'b0001, N'(10 + i), 2'd0);
        idle(2);

        // Wrap: 17 tickets from 14 to requester 1, then clr with two still in flight
        for (int i = 0; i < 17; i++)
            step(4'b0010, 1'b1, 1'b0, 4'b0010, N'((14 + i) % 16), 2'd1);
        check("clr_inflight_busy", int'(busy), 1);
        step(4'b0011, 1'b1, 1'b1, 4'b0000, 4'd0, 2'd0);
        step(4'b0011, 1'b1, 1'b0, 4'b0001, 4'd0, 2'd0);
        step(4'b0011, 1'b1, 1'b0, 4'b0010, 4'd1, 2'd1);
        idle(2);

        // Bubbles: requester 2 on alternate cycles, tickets 2,3,4
        for (int k = 0; k < 8; k++) begin
            automatic bit g0 = (k < 6) && (k % 2 == 0);
            automatic bit g1 = (k >= 1) && ((k - 1) < 6) && ((k - 1) % 2 == 0);
            automatic bit g2 = (k >= 2) && ((k - 2) < 6) && ((k - 2) % 2 == 0);
            check("bubble_valid", int'(out_valid), int'(g2));
            check("bubble_busy", int'(busy), int'(g1 | g2));
            step(g0 ? 4'b0100 : 4'b0000, 1'b1, 1'b0, g0 ? 4'b0100 : 4'b0000,
                 N'(2 + k / 2), 2'd2);
        end

        // Reset mid-stream with two tickets in flight
        step(4'b1000, 1'b1, 1'b0, 4'b1000, 4'd5, 2'd3);
        step(4'b1000, 1'b1, 1'b0, 4'b1000, 4'd6, 2'd3);
        check("pre_reset_valid", int'(out_valid), 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_ticket", int'(out_ticket), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0110, 1'b1, 1'b0, 4'b0010, 4'd0, 2'd1);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
